// File: rtl/digit_entry_editor.sv
// Multi-digit entry editor: synchronised, debounced buttons drive a cursor over
// NUM_DIGITS digits, with up/down auto-repeat and an enter capture into value_o.
module digit_entry_editor #(
   parameter int NUM_DIGITS      = 4,
   parameter int MAX_DIGIT       = 9,
   parameter int WRAP            = 0,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 8,
   parameter int REPEAT_RATE     = 4
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic [4:0]                                           btn,
   input  logic                                                 enable,
   input  logic                                                 load,
   input  logic [4*NUM_DIGITS-1:0]                              load_value,
   output logic [4*NUM_DIGITS-1:0]                              digits_o,
   output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] cursor_o,
   output logic [4*NUM_DIGITS-1:0]                              value_o,
   output logic                                                 done
);

   localparam int CW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW   = 4 * NUM_DIGITS;
   localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DBW-1:0] DB_ONE   = DBW'(1);
   localparam logic [TW-1:0]  T_DELAY  = TW'(REPEAT_DELAY);
   localparam logic [TW-1:0]  T_RATE   = TW'(REPEAT_RATE);
   localparam logic [TW-1:0]  T_ONE    = TW'(1);
   localparam logic [3:0]     MAX_D    = 4'(MAX_DIGIT);
   localparam logic [CW-1:0]  CUR_LAST = CW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0]  CUR_ONE  = CW'(1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] HOLD   = 2'd1;
   localparam logic [1:0] REPEAT = 2'd2;

   logic [4:0]                  sync1_r, sync2_r, deb_r, deb_d_r;
   logic [DBW-1:0]              db_cnt_r [5];
   logic [NUM_DIGITS-1:0][3:0]  digits_r, digits_s;
   logic [CW-1:0]               cursor_r, cursor_s;
   logic [DW-1:0]               value_r, value_s;
   logic                        done_r, done_s;
   logic [1:0]                  state_r, state_s;
   logic                        dir_r, dir_s;
   logic [TW-1:0]               cnt_r, cnt_s;
   logic [4:0]                  press_s;
   logic                        holding_s, exit_s, due_s;

   function automatic logic [3:0] step_digit(input logic [3:0] d, input logic down);
      logic [3:0] r;
      if (down) begin
         if (d == 4'd0) r = (WRAP != 0) ? MAX_D : 4'd0;
         else           r = d - 4'd1;
      end else begin
         if (d >= MAX_D) r = (WRAP != 0) ? 4'd0 : MAX_D;
         else            r = d + 4'd1;
      end
      return r;
   endfunction

   // left moves towards the most significant digit, right towards digit 0
   function automatic logic [CW-1:0] move_cursor(input logic [CW-1:0] c, input logic right);
      logic [CW-1:0] r;
      if (right) begin
         if (c == '0) r = (WRAP != 0) ? CUR_LAST : '0;
         else         r = c - CUR_ONE;
      end else begin
         if (c == CUR_LAST) r = (WRAP != 0) ? '0 : CUR_LAST;
         else               r = c + CUR_ONE;
      end
      return r;
   endfunction

   function automatic logic [NUM_DIGITS-1:0][3:0] clamp_digits(input logic [DW-1:0] v);
      logic [NUM_DIGITS-1:0][3:0] r;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         r[k] = (v[4*k +: 4] > MAX_D) ? MAX_D : v[4*k +: 4];
      end
      return r;
   endfunction

   // Button synchronisers and per-button debounce counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 5'd0;
         sync2_r <= 5'd0;
         deb_r   <= 5'd0;
         deb_d_r <= 5'd0;
         for (int k = 0; k < 5; k++) db_cnt_r[k] <= '0;
      end else begin
         sync1_r <= btn;
         sync2_r <= sync1_r;
         deb_d_r <= deb_r;
         for (int k = 0; k < 5; k++) begin
            if (sync2_r[k] == deb_r[k]) begin
               db_cnt_r[k] <= '0;
            end else if (db_cnt_r[k] == DB_LAST) begin
               deb_r[k]    <= sync2_r[k];
               db_cnt_r[k] <= '0;
            end else begin
               db_cnt_r[k] <= db_cnt_r[k] + DB_ONE;
            end
         end
      end
   end

   // Event arbitration, edit actions and the auto-repeat timer.
   always_comb begin
      press_s   = deb_r & ~deb_d_r;
      holding_s = (state_r != IDLE);
      exit_s    = holding_s && !(dir_r ? deb_r[3] : deb_r[2]);
      due_s     = holding_s && !exit_s && (cnt_r == T_ONE);
      digits_s  = digits_r;
      cursor_s  = cursor_r;
      value_s   = value_r;
      done_s    = 1'b0;
      state_s   = state_r;
      cnt_s     = cnt_r;
      dir_s     = dir_r;
      if (!enable) begin
         state_s = IDLE;
         cnt_s   = '0;
         if (load) begin
            digits_s = clamp_digits(load_value);
            cursor_s = '0;
         end else begin
            digits_s = digits_r;
         end
      end else if (load) begin
         // load freezes the repeat timer rather than cancelling it
         digits_s = clamp_digits(load_value);
         cursor_s = '0;
      end else begin
         if (exit_s) begin
            state_s = IDLE;
            cnt_s   = '0;
         end else if (due_s) begin
            state_s = REPEAT;
            cnt_s   = T_RATE;
         end else if (holding_s) begin
            cnt_s = cnt_r - T_ONE;
         end else begin
            cnt_s = cnt_r;
         end
         if (press_s[4]) begin
            value_s = digits_r;
            done_s  = 1'b1;
         end else if (!holding_s && (press_s[2] || press_s[3])) begin
            dir_s              = !press_s[2];
            digits_s[cursor_r] = step_digit(digits_r[cursor_r], dir_s);
            state_s            = HOLD;
            cnt_s              = T_DELAY;
         end else if (due_s) begin
            digits_s[cursor_r] = step_digit(digits_r[cursor_r], dir_r);
         end else if (press_s[0]) begin
            cursor_s = move_cursor(cursor_r, 1'b0);
         end else if (press_s[1]) begin
            cursor_s = move_cursor(cursor_r, 1'b1);
         end else begin
            done_s = 1'b0;
         end
      end
   end

   // Editor state and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digits_r <= '0;
         cursor_r <= '0;
         value_r  <= '0;
         done_r   <= 1'b0;
         state_r  <= IDLE;
         cnt_r    <= '0;
         dir_r    <= 1'b0;
      end else begin
         digits_r <= digits_s;
         cursor_r <= cursor_s;
         value_r  <= value_s;
         done_r   <= done_s;
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         dir_r    <= dir_s;
      end
   end

   assign digits_o = digits_r;
   assign cursor_o = cursor_r;
   assign value_o  = value_r;
   assign done     = done_r;

endmodule

// File: tb/tb_digit_entry_editor.sv
// Bench: a saturating and a wrapping editor share stimulus and are compared every
// cycle against a timestamp-based reference model of the editing rules.
module tb_digit_entry_editor;

   localparam int ND = 4, MAXD = 9, DB = 4, RD = 8, RR = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  btn = 5'd0;
   logic        enable = 1'b1;
   logic        load = 1'b0;
   logic [15:0] load_value = 16'd0;
   logic [15:0] dig0, dig1, val0, val1;
   logic [1:0]  cur0, cur1;
   logic        done0, done1;

   always #5 clk = ~clk;

   digit_entry_editor #(.NUM_DIGITS(ND), .MAX_DIGIT(MAXD), .WRAP(0), .DEBOUNCE_CYCLES(DB),
                        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u_sat (
      .clk(clk), .rst(rst), .btn(btn), .enable(enable), .load(load), .load_value(load_value),
      .digits_o(dig0), .cursor_o(cur0), .value_o(val0), .done(done0));

   digit_entry_editor #(.NUM_DIGITS(ND), .MAX_DIGIT(MAXD), .WRAP(1), .DEBOUNCE_CYCLES(DB),
                        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u_wrap (
      .clk(clk), .rst(rst), .btn(btn), .enable(enable), .load(load), .load_value(load_value),
      .digits_o(dig1), .cursor_o(cur1), .value_o(val1), .done(done1));

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: index 0 saturates, index 1 wraps
   int          m_dig [2][ND];
   int          m_cur [2];
   logic [15:0] m_val [2];
   logic        m_done [2];
   bit          m_act [2];
   bit          m_dir [2];
   int          m_next [2];
   logic [4:0]  m_deb, m_debd;
   logic [4:0]  rawh [16];
   int          n = 0;

   function automatic logic [15:0] m_pack(input int w);
      logic [15:0] p;
      for (int k = 0; k < ND; k++) p[4*k +: 4] = 4'(m_dig[w][k]);
      return p;
   endfunction

   task automatic m_reset();
      for (int w = 0; w < 2; w++) begin
         for (int k = 0; k < ND; k++) m_dig[w][k] = 0;
         m_cur[w] = 0; m_val[w] = 16'd0; m_done[w] = 1'b0;
         m_act[w] = 0; m_dir[w] = 0; m_next[w] = 0;
      end
      m_deb = 5'd0; m_debd = 5'd0;
      for (int i = 0; i < 16; i++) rawh[i] = 5'd0;
   endtask

   task automatic m_step(input int w, input bit down);
      int d;
      d = m_dig[w][m_cur[w]];
      if (!down) d = (d >= MAXD) ? ((w == 1) ? 0 : MAXD) : d + 1;
      else       d = (d == 0) ? ((w == 1) ? MAXD : 0) : d - 1;
      m_dig[w][m_cur[w]] = d;
   endtask

   task automatic m_load(input int w);
      int nib;
      for (int k = 0; k < ND; k++) begin
         nib = int'(load_value[4*k +: 4]);
         m_dig[w][k] = (nib > MAXD) ? MAXD : nib;
      end
      m_cur[w] = 0;
   endtask

   task automatic m_inst(input int w, input logic [4:0] ev);
      bit hold, ex, due;
      m_done[w] = 1'b0;
      if (!enable) begin
         m_act[w] = 0;
         if (load) m_load(w);
      end else if (load) begin
         m_load(w);
         if (m_act[w]) m_next[w]++;
      end else begin
         hold = m_act[w];
         ex   = hold && !(m_dir[w] ? m_deb[3] : m_deb[2]);
         due  = hold && !ex && (n == m_next[w]);
         if (ex) m_act[w] = 0;
         if (due) m_next[w] = n + RR;
         if (ev[4]) begin
            m_val[w] = m_pack(w); m_done[w] = 1'b1;
         end else if (!hold && (ev[2] || ev[3])) begin
            m_dir[w] = !ev[2]; m_step(w, m_dir[w]); m_act[w] = 1; m_next[w] = n + RD;
         end else if (due) begin
            m_step(w, m_dir[w]);
         end else if (ev[0]) begin
            m_cur[w] = (m_cur[w] == ND-1) ? ((w == 1) ? 0 : ND-1) : m_cur[w] + 1;
         end else if (ev[1]) begin
            m_cur[w] = (m_cur[w] == 0) ? ((w == 1) ? ND-1 : 0) : m_cur[w] - 1;
         end
      end
   endtask

   // one clock edge: act on last edge's press events, then re-debounce from raw history
   task automatic m_edge();
      logic [4:0] ev, nd;
      bit all_diff;
      n++;
      ev = m_deb & ~m_debd;
      for (int w = 0; w < 2; w++) m_inst(w, ev);
      nd = m_deb;
      for (int b = 0; b < 5; b++) begin
         all_diff = 1;
         for (int i = 1; i <= DB; i++) if (rawh[i][b] == m_deb[b]) all_diff = 0;
         if (all_diff) nd[b] = ~m_deb[b];
      end
      m_debd = m_deb;
      m_deb  = nd;
      for (int i = 15; i > 0; i--) rawh[i] = rawh[i-1];
      rawh[0] = btn;
   endtask

   task automatic check_all(input string tag);
      check({tag, "/dig0"}, dig0, m_pack(0));
      check({tag, "/dig1"}, dig1, m_pack(1));
      check({tag, "/cur0"}, cur0, m_cur[0]);
      check({tag, "/cur1"}, cur1, m_cur[1]);
      check({tag, "/val0"}, val0, m_val[0]);
      check({tag, "/val1"}, val1, m_val[1]);
      check({tag, "/done0"}, done0, m_done[0]);
      check({tag, "/done1"}, done1, m_done[1]);
   endtask

   task automatic run(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
         if (rst) m_reset();
         else     m_edge();
         check_all("cyc");
      end
   endtask

   task automatic press(input int b, input int hold, input int gap);
      btn[b] = 1'b1; run(hold);
      btn[b] = 1'b0; run(gap);
   endtask

   task automatic do_load(input logic [15:0] v);
      load_value = v; load = 1'b1; run(1); load = 1'b0;
   endtask

   int exp_l0 [5] = '{1, 2, 3, 3, 3};
   int exp_l1 [5] = '{1, 2, 3, 0, 1};

   initial begin
      m_reset();
      run(3);
      rst = 1'b0;
      check("rst_dig", dig0, 16'h0000);
      check("rst_cur", cur0, 2'd0);
      check("rst_val", val0, 16'h0000);
      check("rst_done", done0, 1'b0);

      // glitch shorter than the debounce window
      btn = 5'b00100; run(3); btn = 5'b00000; run(12);
      check("glitch", dig0, 16'h0000);

      // clean press, latency and repeat cadence
      btn = 5'b00100; run(6);
      check("lat_early", dig0, 16'h0000);
      run(1);
      check("lat0", dig0, 16'h0001);
      check("lat1", dig1, 16'h0001);
      run(7);
      check("delay_hold", dig0, 16'h0001);
      run(1);
      check("rep1", dig0, 16'h0002);
      run(3);
      check("rep_gap", dig0, 16'h0002);
      run(1);
      check("rep2", dig0, 16'h0003);
      run(1);
      btn = 5'b00000; run(15);

      // limits: saturate vs wrap
      do_load(16'h0009); press(2, 6, 12);
      check("up_sat", dig0, 16'h0009);
      check("up_wrap", dig1, 16'h0000);
      do_load(16'h0000); press(3, 6, 12);
      check("dn_sat", dig0, 16'h0000);
      check("dn_wrap", dig1, 16'h0009);

      do_load(16'h0000);
      for (int i = 0; i < 5; i++) begin
         press(0, 6, 12);
         check("left_sat", cur0, exp_l0[i]);
         check("left_wrap", cur1, exp_l1[i]);
      end
      do_load(16'h0000); press(0, 6, 12); press(0, 6, 12); press(2, 6, 12);
      check("up_c2", dig0, 16'h0100);

      // load clamping and enter
      do_load(16'hF123);
      check("clamp", dig0, 16'h9123);
      check("clamp_cur", cur0, 2'd0);
      btn = 5'b10000; run(6);
      check("ent_early", done0, 1'b0);
      run(1);
      check("ent_done", done0, 1'b1);
      check("ent_val", val0, 16'h9123);
      run(1);
      check("ent_once", done0, 1'b0);
      run(48);
      btn = 5'b00000; run(12);

      // simultaneous events
      do_load(16'h0000);
      btn = 5'b00101; run(6); btn = 5'b00000; run(12);
      check("upleft_dig", dig0, 16'h0001);
      check("upleft_cur", cur0, 2'd0);
      btn = 5'b10100; run(7);
      check("entup_done", done0, 1'b1);
      check("entup_dig", dig0, 16'h0001);
      btn = 5'b00000; run(12);

      // reset during repeat with up still held
      btn = 5'b00100; run(22);
      rst = 1'b1; #2;
      m_reset();
      check("rst_mid", dig0, 16'h0000);
      check_all("rst_async");
      run(2);
      rst = 1'b0;
      run(6);
      check("post_rst_early", dig0, 16'h0000);
      run(1);
      check("post_rst", dig0, 16'h0001);
      run(8);
      check("post_rst_rep", dig0, 16'h0002);
      btn = 5'b00000; run(15);

      // randomized traffic
      for (int seg = 0; seg < 450; seg++) begin
         int r, b;
         r = $urandom_range(0, 99);
         if (r < 2) begin
            rst = 1'b1; #2;
            m_reset();
            check_all("rrst");
            run(1);
            rst = 1'b0;
         end else if (r < 10) begin
            do_load(16'($urandom));
         end else if (r < 18) begin
            enable = ($urandom_range(0, 3) != 0);
            run($urandom_range(1, 5));
         end else if (r < 32) begin
            btn = 5'b00000;
            run($urandom_range(1, 12));
         end else begin
            b = $urandom_range(0, 4);
            btn[b] = ~btn[b];
            run($urandom_range(1, 14));
         end
      end
      enable = 1'b1; btn = 5'b00000; run(15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
